// File: rtl/sprite_blitter.sv
// Multi-channel sprite blitter: optional background clear, then per-channel ROM-sourced
// drawing with colour-key transparency and screen clipping. BLITTER_MIRROR_EN adds ch_flip.
module sprite_blitter #(
    parameter int                NUM_CH   = 4,
    parameter int                SCREEN_W = 640,
    parameter int                SCREEN_H = 480,
    parameter int                PIX_W    = 8,
    parameter int                FB_AW    = 19,
    parameter int                DIM_W    = 7,
    parameter int                ROM_AW   = 16,
    parameter logic [PIX_W-1:0]  TRANSP   = 8'hE3
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     start,
    input  logic                     clear_req,
    input  logic [PIX_W-1:0]         bg_color,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH*10-1:0]     ch_x,
    input  logic [NUM_CH*10-1:0]     ch_y,
    input  logic [NUM_CH*DIM_W-1:0]  ch_w,
    input  logic [NUM_CH*DIM_W-1:0]  ch_h,
    input  logic [NUM_CH*ROM_AW-1:0] ch_base,
`ifdef BLITTER_MIRROR_EN
    input  logic [NUM_CH-1:0]        ch_flip,
`endif
    output logic [ROM_AW-1:0]        rom_addr,
    input  logic [PIX_W-1:0]         rom_data,
    output logic [FB_AW-1:0]         fb_wraddr,
    output logic [PIX_W-1:0]         fb_data,
    output logic                     fb_we,
    output logic                     busy,
    output logic                     done
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [FB_AW-1:0] CLR_LAST = FB_AW'(SCREEN_W*SCREEN_H - 1);

    logic [2:0]                       state;
    logic [CH_W-1:0]                  ch;
    logic [PIX_W-1:0]                 bg_q;
    logic [NUM_CH-1:0]                en_q, flip_q;
    logic [NUM_CH-1:0][9:0]           x_q, y_q;
    logic [NUM_CH-1:0][DIM_W-1:0]     w_q, h_q;
    logic [NUM_CH-1:0][ROM_AW-1:0]    base_q;
    logic [FB_AW-1:0]                 clr_addr;
    logic [DIM_W-1:0]                 row, col;
    logic [ROM_AW-1:0]                row_off;
    logic                             s2_vld, s2_on;
    logic [FB_AW-1:0]                 s2_addr;

`ifndef BLITTER_MIRROR_EN
    assign flip_q = '0;
`endif

    logic              cur_en, cur_flip, last_col, last_row;
    logic [9:0]        cur_x, cur_y;
    logic [DIM_W-1:0]  cur_w, cur_h;
    logic [ROM_AW-1:0] cur_base, col_first, col_next;
    logic [10:0]       xsum, ysum;

    assign cur_en   = en_q[ch];
    assign cur_flip = flip_q[ch];
    assign cur_x    = x_q[ch];
    assign cur_y    = y_q[ch];
    assign cur_w    = w_q[ch];
    assign cur_h    = h_q[ch];
    assign cur_base = base_q[ch];
    assign last_col = (col == cur_w - DIM_W'(1));
    assign last_row = (row == cur_h - DIM_W'(1));
    // ROM column offset; mirrored channels walk each row backwards
    assign col_first = cur_flip ? ROM_AW'(cur_w - DIM_W'(1)) : '0;
    assign col_next  = cur_flip ? ROM_AW'(cur_w - col - DIM_W'(2)) : ROM_AW'(col + DIM_W'(1));
    // 11-bit sums so off-screen coordinates can never wrap back on screen
    assign xsum = {1'b0, cur_x} + 11'(col);
    assign ysum = {1'b0, cur_y} + 11'(row);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            ch       <= '0;
            bg_q     <= '0;
            en_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            base_q   <= '0;
`ifdef BLITTER_MIRROR_EN
            flip_q   <= '0;
`endif
            clr_addr <= '0;
            row      <= '0;
            col      <= '0;
            row_off  <= '0;
            rom_addr <= '0;
            s2_vld   <= 1'b0;
            s2_on    <= 1'b0;
            s2_addr  <= '0;
        end else begin
            s2_vld  <= (state == S_DRAW);
            s2_on   <= (xsum < 11'(SCREEN_W)) && (ysum < 11'(SCREEN_H));
            s2_addr <= FB_AW'(32'(ysum) * 32'(SCREEN_W) + 32'(xsum));
            case (state)
                S_IDLE: if (start) begin
                    bg_q     <= bg_color;
                    en_q     <= ch_en;
                    x_q      <= ch_x;
                    y_q      <= ch_y;
                    w_q      <= ch_w;
                    h_q      <= ch_h;
                    base_q   <= ch_base;
`ifdef BLITTER_MIRROR_EN
                    flip_q   <= ch_flip;
`endif
                    ch       <= '0;
                    clr_addr <= '0;
                    state    <= clear_req ? S_CLEAR : S_LOAD;
                end
                S_CLEAR: begin
                    clr_addr <= clr_addr + FB_AW'(1);
                    if (clr_addr == CLR_LAST) state <= S_LOAD;
                end
                S_LOAD: begin
                    if (!cur_en || cur_w == '0 || cur_h == '0) begin
                        state <= S_NEXT;
                    end else begin
                        row      <= '0;
                        col      <= '0;
                        row_off  <= '0;
                        rom_addr <= cur_base + col_first;
                        state    <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (last_col) begin
                        if (last_row) begin
                            state <= S_DRAIN;
                        end else begin
                            col      <= '0;
                            row      <= row + DIM_W'(1);
                            row_off  <= row_off + ROM_AW'(cur_w);
                            rom_addr <= cur_base + row_off + ROM_AW'(cur_w) + col_first;
                        end
                    end else begin
                        col      <= col + DIM_W'(1);
                        rom_addr <= cur_base + row_off + col_next;
                    end
                end
                S_DRAIN: state <= S_NEXT;
                S_NEXT: begin
                    ch    <= ch + CH_W'(1);
                    state <= (ch == CH_W'(NUM_CH - 1)) ? S_DONE : S_LOAD;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write port is decoded from registered state so reset kills it immediately
    assign fb_we     = (state == S_CLEAR) || (s2_vld && s2_on && rom_data != TRANSP);
    assign fb_wraddr = (state == S_CLEAR) ? clr_addr : s2_addr;
    assign fb_data   = (state == S_CLEAR) ? bg_q : (s2_vld ? rom_data : '0);
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter on an 8x4 screen with two channels.
module tb_sprite_blitter;
    localparam int NUM_CH = 2, SW = 8, SH = 4, PIX_W = 8, FB_AW = 5, DIM_W = 7, ROM_AW = 16;

    logic                     Clk, Reset, start, clear_req;
    logic [PIX_W-1:0]         bg_color, rom_data, fb_data;
    logic [NUM_CH-1:0]        ch_en;
    logic [NUM_CH*10-1:0]     ch_x, ch_y;
    logic [NUM_CH*DIM_W-1:0]  ch_w, ch_h;
    logic [NUM_CH*ROM_AW-1:0] ch_base;
    logic [ROM_AW-1:0]        rom_addr;
    logic [FB_AW-1:0]         fb_wraddr;
    logic                     fb_we, busy, done;

    typedef struct packed { logic [FB_AW-1:0] a; logic [PIX_W-1:0] d; } wr_t;
    wr_t exp_q[$];
    logic [7:0] rom [0:65535];
    int checks = 0, errors = 0;

    sprite_blitter #(.NUM_CH(NUM_CH), .SCREEN_W(SW), .SCREEN_H(SH), .PIX_W(PIX_W),
                     .FB_AW(FB_AW), .DIM_W(DIM_W), .ROM_AW(ROM_AW)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .clear_req(clear_req), .bg_color(bg_color),
        .ch_en(ch_en), .ch_x(ch_x), .ch_y(ch_y), .ch_w(ch_w), .ch_h(ch_h), .ch_base(ch_base),
        .rom_addr(rom_addr), .rom_data(rom_data), .fb_wraddr(fb_wraddr), .fb_data(fb_data),
        .fb_we(fb_we), .busy(busy), .done(done));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) rom_data <= rom[rom_addr];

    task automatic set_ch(input int i, input bit en, input int x, input int y,
                          input int w, input int h, input int base);
        ch_en[i]                 = en;
        ch_x[10*i +: 10]         = 10'(x);
        ch_y[10*i +: 10]         = 10'(y);
        ch_w[DIM_W*i +: DIM_W]   = DIM_W'(w);
        ch_h[DIM_W*i +: DIM_W]   = DIM_W'(h);
        ch_base[ROM_AW*i +: ROM_AW] = ROM_AW'(base);
    endtask

    task automatic push_exp(input int a, input int d);
        wr_t e;
        e.a = FB_AW'(a);
        e.d = PIX_W'(d);
        exp_q.push_back(e);
    endtask

    // Pulses start from a negedge, then checks every write against the scoreboard until done.
    task automatic run_frame(input string tag, input bit poke, output int cycles);
        bit got;
        wr_t e;
        start = 1'b1;
        cycles = 0;
        got = 1'b0;
        while (!got && cycles < 2000) begin
            @(negedge Clk);
            cycles++;
            start = poke && (cycles == 3);
            if (poke && cycles == 3) ch_en = '0;
            if (fb_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_write addr=%0d data=%h, expected no write", tag, fb_wraddr, fb_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({fb_wraddr, fb_data} !== {e.a, e.d}) begin
                        errors++;
                        $display("FAIL %s write addr=%0d data=%h, expected addr=%0d data=%h",
                                 tag, fb_wraddr, fb_data, e.a, e.d);
                    end
                end
            end
            if (done) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s done_timeout cycles=%0d, expected done", tag, cycles);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_writes remaining=%0d, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
        start = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        #1;
        checks++;
        if ({fb_we, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl we/busy/done=%b, expected 000", {fb_we, busy, done});
        end
        checks++;
        if (rom_addr !== '0 || fb_wraddr !== '0 || fb_data !== '0) begin
            errors++;
            $display("FAIL reset_data rom=%h wr=%h d=%h, expected 0", rom_addr, fb_wraddr, fb_data);
        end
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_clear;
        int cyc;
        clear_req = 1'b1;
        bg_color = 8'h11;
        ch_en = '0;
        for (int a = 0; a < SW*SH; a++) push_exp(a, 8'h11);
        run_frame("clear", 1'b0, cyc);
        checks++;
        if (cyc != SW*SH + 5) begin
            errors++;
            $display("FAIL clear_latency cycles=%0d, expected %0d", cyc, SW*SH + 5);
        end
    endtask

    task automatic test_draw(input bit transp);
        int cyc;
        clear_req = 1'b0;
        set_ch(0, 1'b1, 2, 1, 2, 2, 16);
        set_ch(1, 1'b0, 0, 0, 1, 1, 0);
        rom[16] = 8'hA1; rom[17] = transp ? 8'hE3 : 8'hA2; rom[18] = 8'hA3; rom[19] = 8'hA4;
        push_exp(10, 8'hA1);
        if (!transp) push_exp(11, 8'hA2);
        push_exp(18, 8'hA3);
        push_exp(19, 8'hA4);
        run_frame(transp ? "transp" : "draw", 1'b0, cyc);
        checks++;
        if (cyc != 10) begin
            errors++;
            $display("FAIL draw_latency cycles=%0d, expected 10", cyc);
        end
    endtask

    task automatic test_clip;
        int cyc;
        clear_req = 1'b0;
        set_ch(0, 1'b1, 7, 3, 3, 2, 32);
        set_ch(1, 1'b0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) rom[32+i] = 8'(8'hB0 + i);
        push_exp(31, 8'hB0);
        run_frame("clip", 1'b0, cyc);
        checks++;
        if (cyc != 12) begin
            errors++;
            $display("FAIL clip_latency cycles=%0d, expected 12", cyc);
        end
    endtask

    task automatic test_overlap_busy;
        int cyc;
        clear_req = 1'b0;
        set_ch(0, 1'b1, 0, 0, 1, 1, 40);
        set_ch(1, 1'b1, 0, 0, 1, 1, 41);
        rom[40] = 8'h22; rom[41] = 8'h33;
        push_exp(0, 8'h22);
        push_exp(0, 8'h33);
        run_frame("overlap", 1'b1, cyc);
        checks++;
        if (cyc != 9) begin
            errors++;
            $display("FAIL overlap_latency cycles=%0d, expected 9", cyc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b0 || fb_we !== 1'b0) begin
                errors++;
                $display("FAIL ignored_start busy=%b we=%b, expected 0 0", busy, fb_we);
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_reset_mid_clear;
        int n, cyc;
        clear_req = 1'b1;
        bg_color = 8'h55;
        ch_en = '0;
        start = 1'b1;
        n = 0;
        @(negedge Clk);
        start = 1'b0;
        while (!(fb_we && fb_wraddr == 5) && n < 100) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL mid_clear_reach addr=%0d, expected to reach 5", fb_wraddr);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (fb_we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset we=%b busy=%b, expected 0 0", fb_we, busy);
        end
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (done !== 1'b0 || fb_we !== 1'b0) begin
                errors++;
                $display("FAIL post_reset done=%b we=%b, expected 0 0", done, fb_we);
            end
            @(negedge Clk);
        end
        bg_color = 8'h44;
        for (int a = 0; a < SW*SH; a++) push_exp(a, 8'h44);
        run_frame("restart", 1'b0, cyc);
        checks++;
        if (cyc != SW*SH + 5) begin
            errors++;
            $display("FAIL restart_latency cycles=%0d, expected %0d", cyc, SW*SH + 5);
        end
    endtask

    initial begin
        start = 1'b0; clear_req = 1'b0; bg_color = '0;
        ch_en = '0; ch_x = '0; ch_y = '0; ch_w = '0; ch_h = '0; ch_base = '0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        test_reset();
        test_clear();
        test_draw(1'b0);
        test_draw(1'b1);
        test_clip();
        test_overlap_busy();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
